// File: rtl/step_pulse_generator_pkg.sv
// Shared definitions for the step pulse generator: FSM encoding, default clock and
// millisecond-to-cycle conversion.
package step_pulse_generator_pkg;

  localparam int unsigned DefaultClockFreqHz = 100_000_000;

  typedef enum logic [1:0] {
    StDisarmed = 2'b00,
    StIdle     = 2'b01,
    StHold     = 2'b10,
    StRepeat   = 2'b11
  } state_e;

  function automatic longint unsigned ms_to_cycles(input longint unsigned freq_hz,
                                                   input longint unsigned ms);
    return (freq_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/step_pulse_generator_if.sv
// Button-side and consumer-side signals of the step pulse generator, grouped as one bundle.
interface step_pulse_generator_if #(
  parameter int unsigned NB_EVENTS = 8
) ();

  logic                 i_signal;
  logic                 i_enable;
  logic                 i_step_ready;
  logic                 o_step_valid;
  logic                 o_holding;
  logic [NB_EVENTS-1:0] o_event_count;
  logic [NB_EVENTS-1:0] o_drop_count;

  modport master (
    output i_signal, i_enable, i_step_ready,
    input  o_step_valid, o_holding, o_event_count, o_drop_count
  );

  modport slave (
    input  i_signal, i_enable, i_step_ready,
    output o_step_valid, o_holding, o_event_count, o_drop_count
  );

endinterface

// File: rtl/step_pulse_generator_hold_timer.sv
// Clearable up-counter that stops at a programmable terminal value and flags expiry.
module step_pulse_generator_hold_timer #(
  parameter int unsigned NB_COUNT = 40
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_run,
  input  logic [NB_COUNT-1:0] i_terminal,
  output logic                o_expired
);

  logic [NB_COUNT-1:0] count_q, count_d;

  // >= keeps the flag sane if the terminal is lowered under a running count
  assign o_expired = (count_q >= i_terminal);

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_run && !o_expired) begin
      count_d = count_q + NB_COUNT'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/step_pulse_generator.sv
// Turns each debounced button press into one buffered step request, with optional
// auto-repeat while the button is held; overflowing requests are counted as drops.
module step_pulse_generator
  import step_pulse_generator_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ    = DefaultClockFreqHz,
  parameter int unsigned HOLD_DELAY_MS    = 500,
  parameter int unsigned REPEAT_PERIOD_MS = 100,
  parameter int unsigned NB_COUNT         = 40,
  parameter int unsigned NB_EVENTS        = 8
) (
  input logic                  i_clock,
  input logic                  i_reset,
  step_pulse_generator_if.slave step_io
);

  localparam bit RepeatEn = (REPEAT_PERIOD_MS != 0);
  localparam logic [NB_COUNT-1:0] HoldTerm =
      NB_COUNT'(ms_to_cycles(64'(CLOCK_FREQ_HZ), 64'(HOLD_DELAY_MS)) - 64'd1);
  localparam logic [NB_COUNT-1:0] RepeatTerm = RepeatEn ?
      NB_COUNT'(ms_to_cycles(64'(CLOCK_FREQ_HZ), 64'(REPEAT_PERIOD_MS)) - 64'd1) : '0;

  state_e state_q, state_d;

  logic                 sig;
  logic                 raw_event;
  logic                 step_event;
  logic                 accept;
  logic                 holding;
  logic                 timer_clear;
  logic                 timer_run;
  logic                 timer_expired;
  logic [NB_COUNT-1:0]  timer_terminal;

  logic                 valid_q, valid_d;
  logic [NB_EVENTS-1:0] event_count_q, event_count_d;
  logic [NB_EVENTS-1:0] drop_count_q, drop_count_d;

  assign sig = step_io.i_signal;

  step_pulse_generator_hold_timer #(
    .NB_COUNT (NB_COUNT)
  ) u_hold_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (timer_clear),
    .i_run      (timer_run),
    .i_terminal (timer_terminal),
    .o_expired  (timer_expired)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StDisarmed;
    end else begin
      state_q <= state_d;
    end
  end

  // A release always wins over a timer expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDisarmed: if (!sig) state_d = StIdle;
      StIdle:     if (sig) state_d = StHold;
      StHold: begin
        if (!sig) begin
          state_d = StIdle;
        end else if (timer_expired && RepeatEn) begin
          state_d = StRepeat;
        end
      end
      StRepeat:   if (!sig) state_d = StIdle;
      default:    state_d = StDisarmed;
    endcase
  end

  always_comb begin
    raw_event      = 1'b0;
    holding        = 1'b0;
    timer_clear    = 1'b1;
    timer_run      = 1'b0;
    timer_terminal = HoldTerm;
    unique case (state_q)
      StIdle: raw_event = sig;
      StHold: begin
        holding     = 1'b1;
        timer_run   = sig;
        timer_clear = !sig;
        if (sig && timer_expired && RepeatEn) begin
          raw_event   = 1'b1;
          timer_clear = 1'b1;
        end
      end
      StRepeat: begin
        holding        = 1'b1;
        timer_terminal = RepeatTerm;
        timer_run      = sig;
        timer_clear    = !sig;
        if (sig && timer_expired) begin
          raw_event   = 1'b1;
          timer_clear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign step_event = raw_event & step_io.i_enable;
  assign accept     = valid_q & step_io.i_step_ready;

  // Single-entry buffer: a request taken in the same cycle frees the slot for a new one.
  always_comb begin
    valid_d       = valid_q;
    event_count_d = event_count_q;
    drop_count_d  = drop_count_q;
    if (step_event) begin
      if (!valid_q || accept) begin
        valid_d       = 1'b1;
        event_count_d = event_count_q + NB_EVENTS'(1);
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + NB_EVENTS'(1);
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q       <= 1'b0;
      event_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      event_count_q <= event_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign step_io.o_step_valid  = valid_q;
  assign step_io.o_holding     = holding;
  assign step_io.o_event_count = event_count_q;
  assign step_io.o_drop_count  = drop_count_q;

endmodule
